// File: rtl/bus_seq_pkg.sv
// Shared definitions for the bus move sequencer: sequencer states, size defaults
// and the index-width helper.
package bus_seq_pkg;

  localparam int NREG_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_TURN  = 2'd3
  } seq_state_e;

  // A single register still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_move_seq_tristate_drv.sv
// Enable-controlled tristate driver: places data on the shared bus only while enabled.
module tristate_drv #(
  parameter int WIDTH = 8
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  inout  wire  [WIDTH-1:0] bus_io
);

  assign bus_io = en_i ? data_i : {WIDTH{1'bz}};

endmodule

// File: rtl/bus_move_seq.sv
// Four-phase register-to-register move sequencer on a shared tristate bus.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
module bus_move_seq
  import bus_seq_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int IW   = idx_width(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ext,
  input  logic [IW-1:0]    cmd_src,
  input  logic [IW-1:0]    cmd_dst,
  input  logic             cmd_ld_en,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [NREG-1:0]  oe,
  output logic [NREG-1:0]  ld,
  inout  wire  [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] rd_data,
  output logic             done,
  output seq_state_e       state_dbg
);

  seq_state_e       state_q, state_d;
  logic             ext_q, ld_en_q;
  logic [IW-1:0]    src_q, dst_q;
  logic [WIDTH-1:0] data_q, rd_data_q;
  logic             accept, drv_en, src_ok, dst_ok, self_move;

  assign accept    = cmd_valid && cmd_ready;
  assign src_ok    = (int'(src_q) < NREG);
  assign dst_ok    = (int'(dst_q) < NREG);
  assign self_move = !ext_q && (src_q == dst_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command fields are frozen at acceptance so the transfer in flight is immune to input changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q     <= 1'b0;
      ld_en_q   <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
    end else begin
      if (accept) begin
        ext_q   <= cmd_ext;
        ld_en_q <= cmd_ld_en;
        src_q   <= cmd_src;
        dst_q   <= cmd_dst;
        data_q  <= cmd_data;
      end
      if (state_q == ST_LOAD) begin
        rd_data_q <= bus;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_DRIVE;
      ST_DRIVE: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_TURN;
      ST_TURN:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Internal drive and register enables are mutually exclusive by construction (ext_q selects one).
  always_comb begin
    cmd_ready = 1'b0;
    oe        = '0;
    ld        = '0;
    done      = 1'b0;
    drv_en    = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_DRIVE, ST_LOAD: begin
        if (ext_q) begin
          drv_en = 1'b1;
        end else if (src_ok) begin
          oe = {{(NREG-1){1'b0}}, 1'b1} << src_q;
        end
        if ((state_q == ST_LOAD) && ld_en_q && dst_ok && !self_move) begin
          ld = {{(NREG-1){1'b0}}, 1'b1} << dst_q;
        end
      end
      ST_TURN: done = 1'b1;
      default: ;
    endcase
  end

  tristate_drv #(
    .WIDTH (WIDTH)
  ) u_drv (
    .en_i   (drv_en),
    .data_i (data_q),
    .bus_io (bus)
  );

  assign rd_data   = rd_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bus_move_seq.sv
// Self-checking bench for bus_move_seq with a small register file model on the bus.
module tb_bus_move_seq;
  import bus_seq_pkg::*;

  localparam int NREG  = 4;
  localparam int WIDTH = 8;
  localparam int IW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_ext = 1'b0;
  logic [IW-1:0]    cmd_src = '0;
  logic [IW-1:0]    cmd_dst = '0;
  logic             cmd_ld_en = 1'b0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [NREG-1:0]  oe;
  logic [NREG-1:0]  ld;
  wire  [WIDTH-1:0] bus;
  logic [WIDTH-1:0] rd_data;
  logic             done;
  seq_state_e       state_dbg;

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] exp_q [$];
  int               acc_q [$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;

  bus_move_seq #(.NREG(NREG), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ext   (cmd_ext),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_ld_en (cmd_ld_en),
    .cmd_data  (cmd_data),
    .oe        (oe),
    .ld        (ld),
    .bus       (bus),
    .rd_data   (rd_data),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model sharing the bus
  for (genvar g = 0; g < NREG; g++) begin : g_reg_drv
    assign bus = oe[g] ? regs[g] : {WIDTH{1'bz}};
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (ld[i]) regs[i] <= bus;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rel(input string name);
    n_checks++;
    if (!($isunknown(bus) || (bus == '0))) begin
      n_fail++;
      $display("FAIL %s: bus driven with 0x%0h, expected high-impedance (t=%0t)", name, bus, $time);
    end
  endtask

  // Monitor: scoreboard pop on done, plus bus contention checker every cycle
  always @(negedge clk) begin : monitor
    int idx;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else if (done) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'(0));
      end else begin
        check("sb_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        check("sb_done_latency", 32'(cyc - acc_q.pop_front()), 32'(3));
      end
    end
    check("contention_oe_onehot", 32'($countones(oe) <= 1), 32'(1));
    if (oe != '0) begin
      idx = 0;
      for (int i = 0; i < NREG; i++) if (oe[i]) idx = i;
      check("contention_bus_vs_src", 32'(bus), 32'(regs[idx]));
    end
  end

  // One complete transfer with cycle-by-cycle expectations for DRIVE, LOAD and TURN
  task automatic issue(input logic ext, input logic [IW-1:0] src, input logic [IW-1:0] dst,
                       input logic ld_en, input logic [WIDTH-1:0] data,
                       input logic [NREG-1:0] exp_oe, input logic [NREG-1:0] exp_ld,
                       input logic [WIDTH-1:0] exp_bus, input logic [WIDTH-1:0] exp_rd);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ext = ext; cmd_src = src; cmd_dst = dst;
    cmd_ld_en = ld_en; cmd_data = data;
    while (!cmd_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", 32'(cmd_ready), 32'(1));
    exp_q.push_back(exp_rd);
    acc_q.push_back(cyc);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_ext = ~ext; cmd_src = ~src; cmd_dst = ~dst;
    cmd_ld_en = ~ld_en; cmd_data = ~data;
    check("drive_ready", 32'(cmd_ready), 32'(0));
    check("drive_oe", 32'(oe), 32'(exp_oe));
    check("drive_ld", 32'(ld), 32'(0));
    check("drive_bus", 32'(bus), 32'(exp_bus));
    @(negedge clk);
    check("load_ready", 32'(cmd_ready), 32'(0));
    check("load_oe", 32'(oe), 32'(exp_oe));
    check("load_ld", 32'(ld), 32'(exp_ld));
    check("load_bus", 32'(bus), 32'(exp_bus));
    @(negedge clk);
    check("turn_ready", 32'(cmd_ready), 32'(0));
    check("turn_oe", 32'(oe), 32'(0));
    check("turn_ld", 32'(ld), 32'(0));
    check("turn_done", 32'(done), 32'(1));
    check_rel("turn_bus");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'(1));
    check("rst_oe", 32'(oe), 32'(0));
    check("rst_ld", 32'(ld), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check_rel("rst_bus");
    rst = 1'b0;

    //     ext   src    dst    ld_en data   exp_oe   exp_ld   exp_bus exp_rd
    issue(1'b1, 2'd0, 2'd2, 1'b1, 8'hA5, 4'b0000, 4'b0100, 8'hA5, 8'hA5);
    check("ext_load_reg2", 32'(regs[2]), 32'(8'hA5));
    issue(1'b1, 2'd0, 2'd1, 1'b1, 8'h3C, 4'b0000, 4'b0010, 8'h3C, 8'h3C);
    issue(1'b1, 2'd0, 2'd3, 1'b1, 8'h0F, 4'b0000, 4'b1000, 8'h0F, 8'h0F);
    issue(1'b0, 2'd1, 2'd0, 1'b1, 8'h00, 4'b0010, 4'b0001, 8'h3C, 8'h3C);
    check("reg_move_reg0", 32'(regs[0]), 32'(8'h3C));
    issue(1'b0, 2'd3, 2'd3, 1'b1, 8'h00, 4'b1000, 4'b0000, 8'h0F, 8'h0F);
    check("self_move_reg3", 32'(regs[3]), 32'(8'h0F));
    issue(1'b0, 2'd2, 2'd1, 1'b0, 8'h00, 4'b0100, 4'b0000, 8'hA5, 8'hA5);
    check("read_only_reg1", 32'(regs[1]), 32'(8'h3C));
    issue(1'b1, 2'd0, 2'd0, 1'b0, 8'h5A, 4'b0000, 4'b0000, 8'h5A, 8'h5A);
    check("ext_read_reg0", 32'(regs[0]), 32'(8'h3C));

    // Back-to-back: cmd_valid held high across two commands
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ext = 1'b1; cmd_src = 2'd0; cmd_dst = 2'd1;
    cmd_ld_en = 1'b1; cmd_data = 8'h11;
    check("b2b_ready_c0", 32'(cmd_ready), 32'(1));
    exp_q.push_back(8'h11);
    acc_q.push_back(cyc);
    @(negedge clk);
    cmd_ext = 1'b0; cmd_src = 2'd1; cmd_dst = 2'd2; cmd_data = 8'hEE;
    check("b2b_ready_c1", 32'(cmd_ready), 32'(0));
    check("b2b_frozen_bus", 32'(bus), 32'(8'h11));
    @(negedge clk);
    check("b2b_ready_c2", 32'(cmd_ready), 32'(0));
    check("b2b_ld_c2", 32'(ld), 32'(4'b0010));
    @(negedge clk);
    check("b2b_ready_c3", 32'(cmd_ready), 32'(0));
    @(negedge clk);
    check("b2b_ready_c4", 32'(cmd_ready), 32'(1));
    exp_q.push_back(8'h11);
    acc_q.push_back(cyc);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_second_oe", 32'(oe), 32'(4'b0010));
    check("b2b_second_bus", 32'(bus), 32'(8'h11));
    repeat (3) @(negedge clk);
    check("b2b_reg2", 32'(regs[2]), 32'(8'h11));
    check("b2b_reg1", 32'(regs[1]), 32'(8'h11));

    // Reset in DRIVE of an ext load, with cmd_valid asserted during reset
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ext = 1'b1; cmd_src = 2'd0; cmd_dst = 2'd0;
    cmd_ld_en = 1'b1; cmd_data = 8'h77;
    check("abort_ready", 32'(cmd_ready), 32'(1));
    exp_q.push_back(8'h77);
    acc_q.push_back(cyc);
    @(negedge clk);
    check("abort_drive_bus", 32'(bus), 32'(8'h77));
    rst = 1'b1; cmd_data = 8'h99;
    @(negedge clk);
    check("abort_oe", 32'(oe), 32'(0));
    check("abort_ld", 32'(ld), 32'(0));
    check("abort_rd_data", 32'(rd_data), 32'(0));
    check("abort_ready_after", 32'(cmd_ready), 32'(1));
    check_rel("abort_bus");
    @(negedge clk);
    check("abort_hold_ld", 32'(ld), 32'(0));
    check("abort_hold_oe", 32'(oe), 32'(0));
    check_rel("abort_hold_bus");
    rst = 1'b0; cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_reg0_kept", 32'(regs[0]), 32'(8'h3C));
    check("abort_rd_data_kept", 32'(rd_data), 32'(0));
    check("abort_no_done", 32'(done), 32'(0));

    repeat (2) @(negedge clk);
    check("sb_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
